// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths and index/word types for the 16-bit core.
package cpu_pkg;
  localparam int N    = 16;
  localparam int REGS = 8;
  localparam int AW   = $clog2(REGS);
  typedef logic [AW-1:0] reg_idx_t;
  typedef logic [N-1:0]  word_t;
endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: REGS x N register file, 2 async read ports, 1 sync write port, r0 hardwired to 0.
// Ports: clk/rst_n, we/waddr/wdata write port, raddr1/raddr2 -> rdata1/rdata2 read ports.
// WB_BYPASS_EN: when defined, a read of the address being written this cycle returns wdata.
module regfile_2r1w
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [N-1:0]  rdata1,
  output logic [N-1:0]  rdata2
);
  word_t mem [REGS];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < REGS; i++) mem[i] <= '0;
    else if (we && waddr != '0) mem[waddr] <= wdata;
`ifdef WB_BYPASS_EN
  assign rdata1 = (raddr1 == '0) ? '0 : (we && waddr == raddr1) ? wdata : mem[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : (we && waddr == raddr2) ? wdata : mem[raddr2];
`else
  assign rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : mem[raddr2];
`endif
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: register read, pending-write scoreboard and one registered operand stage.
// Ports: issue_valid/issue_ready + rs1/rs2/rd addresses in; wb_en/wb_addr/wb_data writeback;
// out_valid/out_ready handshake with rs1_reg/rs2_reg/rd_q out.
// WB_BYPASS_EN: when defined, a same-cycle writeback unblocks and feeds a dependent issue.
module operand_fetch
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue_valid,
  output logic          issue_ready,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  input  logic [AW-1:0] rd_addr,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [N-1:0]  wb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  rs1_reg,
  output logic [N-1:0]  rs2_reg,
  output logic [AW-1:0] rd_q
);
  localparam logic [REGS-1:0] R0 = 1;
  logic [REGS-1:0] pending, pend_eff, wb_mask, set_mask;
  word_t rd1, rd2;
  logic hazard, accept;
  regfile_2r1w u_rf (
    .clk(clk), .rst_n(rst_n),
    .we(wb_en), .waddr(wb_addr), .wdata(wb_data),
    .raddr1(rs1_addr), .raddr2(rs2_addr),
    .rdata1(rd1), .rdata2(rd2)
  );
  assign wb_mask = wb_en ? R0 << wb_addr : '0;
`ifdef WB_BYPASS_EN
  assign pend_eff = pending & ~wb_mask;
`else
  assign pend_eff = pending;
`endif
  assign hazard      = pend_eff[rs1_addr] | pend_eff[rs2_addr] | pend_eff[rd_addr];
  assign issue_ready = (!out_valid || out_ready) && !hazard;
  assign accept      = issue_valid && issue_ready;
  assign set_mask    = accept ? R0 << rd_addr : '0;
  // set is OR'd after the clear so a same-cycle issue to a retiring register keeps it pending
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pending <= '0;
    else pending <= ((pending & ~wb_mask) | set_mask) & ~R0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      rs1_reg   <= '0;
      rs2_reg   <= '0;
      rd_q      <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      rs1_reg   <= rd1;
      rs2_reg   <= rd2;
      rd_q      <= rd_addr;
    end else if (out_ready) out_valid <= 1'b0;
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: scoreboard bench for operand_fetch with directed vectors.
module tb_operand_fetch;
  import cpu_pkg::*;
  typedef struct {
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic [AW-1:0] d;
  } exp_t;
  logic clk = 0, rst_n = 0;
  logic issue_valid = 0, issue_ready, wb_en = 0, out_valid, out_ready = 1;
  logic [AW-1:0] rs1_addr = 0, rs2_addr = 0, rd_addr = 0, wb_addr = 0, rd_q;
  logic [N-1:0] wb_data = 0, rs1_reg, rs2_reg;
  int checks = 0, failures = 0;
  exp_t sb[$];
  operand_fetch dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .rs1_reg(rs1_reg), .rs2_reg(rs2_reg), .rd_q(rd_q)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic push(input logic [N-1:0] a, input logic [N-1:0] b, input logic [AW-1:0] d);
    exp_t e;
    e.a = a; e.b = b; e.d = d;
    sb.push_back(e);
  endtask
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_output", 32'(out_valid), 32'(0));
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_rs1", 32'(rs1_reg), 32'(e.a));
        chk("sb_rs2", 32'(rs2_reg), 32'(e.b));
        chk("sb_rd", 32'(rd_q), 32'(e.d));
      end
    end
  task automatic issue(input logic [AW-1:0] s1, input logic [AW-1:0] s2, input logic [AW-1:0] d,
                       input logic [N-1:0] a, input logic [N-1:0] b);
    bit done = 0;
    rs1_addr = s1; rs2_addr = s2; rd_addr = d; issue_valid = 1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (issue_ready) begin
        push(a, b, d);
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) chk("issue_timeout", 32'(0), 32'(1));
    issue_valid = 0;
  endtask
  task automatic wb(input logic [AW-1:0] ad, input logic [N-1:0] dat);
    wb_en = 1; wb_addr = ad; wb_data = dat;
    @(posedge clk); #1;
    wb_en = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_rs1", 32'(rs1_reg), 32'(0));
    chk("rst_rs2", 32'(rs2_reg), 32'(0));
    chk("rst_rd", 32'(rd_q), 32'(0));
    chk("rst_issue_ready", 32'(issue_ready), 32'(1));
    rst_n = 1;
    @(posedge clk); #1;
    issue(3'd0, 3'd0, 3'd1, 16'h0000, 16'h0000);
    chk("latency_out_valid", 32'(out_valid), 32'(1));
    wb(3'd2, 16'h00A5);
    wb(3'd3, 16'h0013);
    issue(3'd2, 3'd3, 3'd4, 16'h00A5, 16'h0013);
    issue(3'd0, 3'd0, 3'd5, 16'h0000, 16'h0000);
    rs1_addr = 3'd5; rs2_addr = 3'd0; rd_addr = 3'd6; issue_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("raw_stall", 32'(issue_ready), 32'(0));
      @(posedge clk); #1;
    end
    wb_en = 1; wb_addr = 3'd5; wb_data = 16'h1234;
    @(negedge clk);
`ifdef WB_BYPASS_EN
    chk("bypass_ready", 32'(issue_ready), 32'(1));
    push(16'h1234, 16'h0000, 3'd6);
    @(posedge clk); #1;
    wb_en = 0; issue_valid = 0;
`else
    chk("wb_cycle_ready", 32'(issue_ready), 32'(0));
    @(posedge clk); #1;
    wb_en = 0;
    @(negedge clk);
    chk("after_wb_ready", 32'(issue_ready), 32'(1));
    push(16'h1234, 16'h0000, 3'd6);
    @(posedge clk); #1;
    issue_valid = 0;
`endif
    issue(3'd2, 3'd3, 3'd7, 16'h00A5, 16'h0013);
    out_ready = 0;
    rs1_addr = 3'd3; rs2_addr = 3'd2; rd_addr = 3'd0; issue_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'(1));
      chk("hold_rs1", 32'(rs1_reg), 32'(16'h00A5));
      chk("hold_rs2", 32'(rs2_reg), 32'(16'h0013));
      chk("hold_rd", 32'(rd_q), 32'(7));
      chk("hold_issue_ready", 32'(issue_ready), 32'(0));
      @(posedge clk); #1;
    end
    out_ready = 1;
    @(negedge clk);
    chk("b2b_ready0", 32'(issue_ready), 32'(1));
    push(16'h0013, 16'h00A5, 3'd0);
    @(posedge clk); #1;
    rs1_addr = 3'd0; rs2_addr = 3'd3; rd_addr = 3'd0;
    @(negedge clk);
    chk("b2b_ready1", 32'(issue_ready), 32'(1));
    push(16'h0000, 16'h0013, 3'd0);
    @(posedge clk); #1;
    issue_valid = 0;
    wb(3'd0, 16'hFFFF);
    issue(3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000);
    chk("r0_not_pending", 32'(dut.pending[0]), 32'(0));
    issue(3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000);
    issue(3'd0, 3'd0, 3'd5, 16'h0000, 16'h0000);
    out_ready = 0;
    @(negedge clk);
    chk("pre_rst_valid", 32'(out_valid), 32'(1));
    chk("pre_rst_pending5", 32'(dut.pending[5]), 32'(1));
    #2 rst_n = 0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'(0));
    chk("async_rst_pending", 32'(dut.pending), 32'(0));
    void'(sb.pop_back());
    @(posedge clk); #1;
    rst_n = 1; out_ready = 1;
    issue(3'd5, 3'd2, 3'd5, 16'h0000, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch stage of the 16-bit core. It holds the architectural register file, reads two source operands per issued instruction, and presents them on `rs1_reg`/`rs2_reg` to the execute units (subtractor and the other ALU slices) through one registered pipeline stage. A per-register pending scoreboard stalls issue on hazards against results not yet written back. The writeback port accepts results such as `sub_rd` coming back from execute.

## Interface
- `N`, 16: data width; equals the execute-unit operand width.
- `REGS`, 8: number of architectural registers.
- `AW`, 3: register index width, `$clog2(REGS)`.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `issue_valid` input 1: an instruction is offered.
- `issue_ready` output 1: the stage accepts the instruction this cycle.
- `rs1_addr` input AW: source 1 index.
- `rs2_addr` input AW: source 2 index.
- `rd_addr` input AW: destination index.
- `wb_en` input 1: writeback strobe.
- `wb_addr` input AW: writeback index.
- `wb_data` input N: writeback value.
- `out_valid` output 1: the operand register holds a valid entry.
- `out_ready` input 1: execute consumes the entry.
- `rs1_reg` output N: source 1 operand.
- `rs2_reg` output N: source 2 operand.
- `rd_q` output AW: destination index travelling with the operands.

## Operation
- The register file has REGS×N entries, all 0 at reset.
  - r0 always reads 0. Writes to r0 are ignored.
  - r0 is never marked pending.
- `pending[REGS]` scoreboard:
  - An issue sets bit `rd_addr` when it is accepted.
  - `wb_en` clears bit `wb_addr`.
- `hazard` = `pending[rs1_addr] | pending[rs2_addr] | pending[rd_addr]`. The `rd_addr` term covers write-after-write.
- `issue_ready = (!out_valid | out_ready) & !hazard`.
- The issue is accepted when `issue_valid & issue_ready`. On acceptance the output register loads the register-file read of rs1/rs2 and `rd_addr`, and `out_valid` is set to 1.
- If `out_valid & out_ready` and no issue is accepted, `out_valid` is cleared to 0. `rs1_reg`, `rs2_reg` and `rd_q` keep their last values.
- When `out_valid & !out_ready`, the outputs are held stable.
- Boundary conditions:
  - Same-cycle set and clear of the same pending bit: set wins.
  - Writeback and issue read of the same index in the same cycle: the operand gets the old value unless `WB_BYPASS_EN` is defined.
  - Reset asserted mid-operation: the in-flight output is dropped and all pending bits are cleared immediately. Register contents return to 0.
- Arithmetic: no carries or width changes. Data passes through unmodified at N bits.

## Timing
- Reset values:
  - `out_valid`=0, `rs1_reg`=0, `rs2_reg`=0, `rd_q`=0.
  - `pending`=0.
  - `issue_ready`=1, since it is combinational on the reset state.
- Latency: an issue accepted at edge k gives `out_valid`=1 with operands after edge k, i.e. 1 cycle.
- Throughput: 1 instruction per cycle when execute holds `out_ready`=1 and there are no hazards.
- Writeback: the write is visible to reads in the cycle after the `wb_en` edge, or in the same cycle with bypass. The pending bit clears at the same edge as the write.
- `issue_ready` is combinational from `out_valid`, `out_ready`, the addresses, `pending` and (with bypass) `wb_en`/`wb_addr`. There is no path from `issue_valid`.

## Configuration
- `WB_BYPASS_EN` defined:
  - A same-cycle `wb_en` to address A masks `pending[A]` in the hazard check.
  - Operand reads of A return `wb_data`, so a dependent instruction issues in the writeback cycle.
- `WB_BYPASS_EN` undefined:
  - The hazard check uses the registered `pending` only.
  - A dependent instruction issues one cycle after writeback, and reads come from the register array only.

## Structure
- Package `cpu_pkg`:
  - Holds the `N`, `REGS` and `AW` constants.
  - Holds `typedef logic [AW-1:0] reg_idx_t` and `typedef logic [N-1:0] word_t`.
- Sub-module `regfile_2r1w` contains:
  - The storage array, with 2 asynchronous read ports and 1 synchronous write port.
  - The r0 read-zero rule.
  - The bypass mux.
- The pending scoreboard, the handshake and the output register stay in `operand_fetch`.

## Test plan
- After reset, issue rs1=0, rs2=0, rd=1: expect `issue_ready`=1 and `out_valid`=1 next cycle with `rs1_reg`=0, `rs2_reg`=0, `rd_q`=1.
- wb r2=16'h00A5 and r3=16'h0013, then issue rs1=2, rs2=3, rd=4: expect `rs1_reg`=16'h00A5, `rs2_reg`=16'h0013.
- Issue rd=5, then issue rs1=5 with no writeback: expect `issue_ready`=0 until `wb_en` with addr 5 and data 16'h1234. The dependent instruction then issues in the same cycle (bypass) or the next cycle (no bypass), and `rs1_reg`=16'h1234.
- Hold `out_ready`=0 for 3 cycles with `out_valid`=1: expect the outputs stable and `issue_ready`=0. Releasing `out_ready` with `issue_valid` high: expect back-to-back acceptance.
- wb r0=16'hFFFF, then read rs1=0: expect `rs1_reg`=0 and `pending[0]` never set.
- Assert `rst_n`=0 while `out_valid`=1 and `pending[5]`=1: expect `out_valid`=0 immediately. After release, issue rs1=5 is accepted and reads 0.
